// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache ports, the shared RAM port and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              ram_err;
    logic [CNT_W-1:0]  icount;
    logic [CNT_W-1:0]  dcount;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               ram_err, icount, dcount
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               ram_err, icount, dcount
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one single-ported RAM between icache and dcache, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate priority; otherwise the dcache always wins.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               CLK,
    input  logic               RST,
    cache_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_e;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   icount_q, icount_d;
    logic [CNT_W-1:0]   dcount_q, dcount_d;
    logic               err_q, err_d;

    logic               i_req_s;
    logic               d_req_s;
    logic               done_s;
    logic               pick_i_s;
    logic               iwait_s;
    logic               dwait_s;
    logic               ram_ren_s;
    logic               ram_wen_s;
    logic [ADDR_W-1:0]  ram_addr_s;
    logic [DATA_W-1:0]  ram_store_s;

    assign i_req_s = bus.iREN;
    assign d_req_s = bus.dREN | bus.dWEN;
    assign done_s  = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);

`ifdef ARB_ROUND_ROBIN_EN
    // rr_q high means the icache is preferred on the next contested IDLE cycle.
    logic rr_q, rr_d;
    assign pick_i_s = i_req_s & (~d_req_s | rr_q);
`else
    assign pick_i_s = i_req_s & ~d_req_s;
`endif

    // State, counters and sticky error register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            icount_q <= {CNT_W{1'b0}};
            dcount_q <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
            dcount_q <= dcount_d;
            err_q    <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q     <= rr_d;
`endif
        end
    end

    // Next-state logic plus the combinational RAM and wait outputs.
    always_comb begin
        state_d     = state_q;
        icount_d    = icount_q;
        dcount_d    = dcount_q;
        err_d       = err_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif
        iwait_s     = 1'b1;
        dwait_s     = 1'b1;
        ram_ren_s   = 1'b0;
        ram_wen_s   = 1'b0;
        ram_addr_s  = bus.iaddr;
        ram_store_s = bus.dstore;

        case (state_q)
            IDLE: begin
                if (pick_i_s) begin
                    state_d = IGNT;
                end else if (d_req_s) begin
                    state_d = DGNT;
                end else begin
                    state_d = IDLE;
                end
            end
            IGNT: begin
                ram_addr_s = bus.iaddr;
                if (!i_req_s) begin
                    state_d = IDLE;
                end else begin
                    ram_ren_s = 1'b1;
                    if (done_s) begin
                        iwait_s  = 1'b0;
                        icount_d = icount_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        err_d    = err_q | (bus.ramstate == RAM_ERROR);
                        state_d  = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_d     = 1'b0;
`endif
                    end else begin
                        state_d = IGNT;
                    end
                end
            end
            DGNT: begin
                ram_addr_s = bus.daddr;
                if (!d_req_s) begin
                    state_d = IDLE;
                end else begin
                    // A simultaneous read and write request is served as a write.
                    ram_wen_s = bus.dWEN;
                    ram_ren_s = bus.dREN & ~bus.dWEN;
                    if (done_s) begin
                        dwait_s  = 1'b0;
                        dcount_d = dcount_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        err_d    = err_q | (bus.ramstate == RAM_ERROR);
                        state_d  = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_d     = 1'b1;
`endif
                    end else begin
                        state_d = DGNT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.iwait    = iwait_s;
    assign bus.dwait    = dwait_s;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.ramREN   = ram_ren_s;
    assign bus.ramWEN   = ram_wen_s;
    assign bus.ramaddr  = ram_addr_s;
    assign bus.ramstore = ram_store_s;
    assign bus.ram_err  = err_q;
    assign bus.icount   = icount_q;
    assign bus.dcount   = dcount_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a transaction model.
module tb_cache_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Transaction-level model: who owns the RAM, counts, sticky error, preference.
    int          m_owner;   // 0 none, 1 icache, 2 dcache
    logic [15:0] m_icnt;
    logic [15:0] m_dcnt;
    logic        m_err;
    logic        m_pref_i;

    always @(posedge CLK) begin
        if (RST) begin
            m_owner  <= 0;
            m_icnt   <= 16'd0;
            m_dcnt   <= 16'd0;
            m_err    <= 1'b0;
            m_pref_i <= 1'b0;
        end else if (m_owner == 0) begin
            if ((bus.dREN || bus.dWEN) && !(bus.iREN && RR && m_pref_i))
                m_owner <= 2;
            else if (bus.iREN)
                m_owner <= 1;
        end else if (m_owner == 1) begin
            if (!bus.iREN) m_owner <= 0;
            else if (bus.ramstate >= 2'd2) begin
                m_owner  <= 0;
                m_icnt   <= m_icnt + 16'd1;
                m_err    <= m_err | (bus.ramstate == 2'd3);
                m_pref_i <= 1'b0;
            end
        end else begin
            if (!(bus.dREN || bus.dWEN)) m_owner <= 0;
            else if (bus.ramstate >= 2'd2) begin
                m_owner  <= 0;
                m_dcnt   <= m_dcnt + 16'd1;
                m_err    <= m_err | (bus.ramstate == 2'd3);
                m_pref_i <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            logic        d_req;
            logic        e_iwait, e_dwait, e_ren, e_wen;
            logic [31:0] e_addr;
            d_req   = bus.dREN | bus.dWEN;
            e_iwait = !(m_owner == 1 && bus.iREN && bus.ramstate[1]);
            e_dwait = !(m_owner == 2 && d_req && bus.ramstate[1]);
            e_ren   = (m_owner == 1) ? bus.iREN :
                      (m_owner == 2) ? (bus.dREN & ~bus.dWEN) : 1'b0;
            e_wen   = (m_owner == 2) ? bus.dWEN : 1'b0;
            e_addr  = (m_owner == 2) ? bus.daddr : bus.iaddr;
            chk("m_iwait", 64'(bus.iwait), 64'(e_iwait));
            chk("m_dwait", 64'(bus.dwait), 64'(e_dwait));
            chk("m_ramREN", 64'(bus.ramREN), 64'(e_ren));
            chk("m_ramWEN", 64'(bus.ramWEN), 64'(e_wen));
            chk("m_ramaddr", 64'(bus.ramaddr), 64'(e_addr));
            if (m_owner != 1) chk("m_ramstore", 64'(bus.ramstore), 64'(bus.dstore));
            chk("m_iload", 64'(bus.iload), 64'(bus.ramload));
            chk("m_dload", 64'(bus.dload), 64'(bus.ramload));
            chk("m_ram_err", 64'(bus.ram_err), 64'(m_err));
            chk("m_icount", 64'(bus.icount), 64'(m_icnt));
            chk("m_dcount", 64'(bus.dcount), 64'(m_dcnt));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN = 1'b0; bus.iaddr = 32'd0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = 32'd0; bus.dstore = 32'd0;
        bus.ramload = 32'd0; bus.ramstate = 2'd0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        string order;
        string exp_order;
        idle_inputs();
        tick();
        chk_en = 1'b1;
        do_reset();
        #1;
        chk("rst_iwait", 64'(bus.iwait), 64'd1);
        chk("rst_dwait", 64'(bus.dwait), 64'd1);
        chk("rst_ramREN", 64'(bus.ramREN), 64'd0);
        chk("rst_ramWEN", 64'(bus.ramWEN), 64'd0);
        chk("rst_err", 64'(bus.ram_err), 64'd0);
        chk("rst_icount", 64'(bus.icount), 64'd0);

        // icache read with three BUSY cycles
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd1;
        #1 chk("t1_idle_ren", 64'(bus.ramREN), 64'd0);
        tick();
        #1 chk("t1_ren", 64'(bus.ramREN), 64'd1);
        chk("t1_addr", 64'(bus.ramaddr), 64'h40);
        chk("t1_busy_iwait", 64'(bus.iwait), 64'd1);
        tick();
        tick();
        bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
        #1 chk("t1_iwait", 64'(bus.iwait), 64'd0);
        chk("t1_iload", 64'(bus.iload), 64'hDEADBEEF);
        tick();
        bus.iREN = 1'b0; bus.ramstate = 2'd0;
        #1 chk("t1_iwait_after", 64'(bus.iwait), 64'd1);
        chk("t1_icount", 64'(bus.icount), 64'd1);

        // simultaneous requests: dcache write first, icache after the IDLE gap
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678; bus.ramstate = 2'd1;
        tick();
        #1 chk("t2_wen", 64'(bus.ramWEN), 64'd1);
        chk("t2_addr", 64'(bus.ramaddr), 64'h80);
        chk("t2_store", 64'(bus.ramstore), 64'h12345678);
        bus.ramstate = 2'd2;
        #1 chk("t2_dwait", 64'(bus.dwait), 64'd0);
        tick();
        bus.dWEN = 1'b0; bus.ramstate = 2'd1;
        #1 chk("t2_gap_ren", 64'(bus.ramREN), 64'd0);
        chk("t2_dcount", 64'(bus.dcount), 64'd1);
        tick();
        #1 chk("t2_i_ren", 64'(bus.ramREN), 64'd1);
        chk("t2_i_addr", 64'(bus.ramaddr), 64'h44);
        bus.ramstate = 2'd2;
        #1 chk("t2_iwait", 64'(bus.iwait), 64'd0);
        tick();
        bus.iREN = 1'b0; bus.ramstate = 2'd0;
        #1 chk("t2_icount", 64'(bus.icount), 64'd1);
        chk("t2_dcount2", 64'(bus.dcount), 64'd1);

        // read+write together, then a dcache read aborted while BUSY
        do_reset();
        bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.ramstate = 2'd1;
        tick();
        #1 chk("t3_wen", 64'(bus.ramWEN), 64'd1);
        chk("t3_ren", 64'(bus.ramREN), 64'd0);
        bus.dWEN = 1'b0;
        #1 chk("t4_ren", 64'(bus.ramREN), 64'd1);
        bus.dREN = 1'b0;
        #1 chk("t4_abort_ren", 64'(bus.ramREN), 64'd0);
        chk("t4_abort_dwait", 64'(bus.dwait), 64'd1);
        tick();
        bus.dREN = 1'b1;
        #1 chk("t4_idle_ren", 64'(bus.ramREN), 64'd0);
        chk("t4_dcount", 64'(bus.dcount), 64'd0);
        bus.dREN = 1'b0;

        // ERROR completion sets the sticky flag until reset
        do_reset();
        bus.iREN = 1'b1; bus.ramstate = 2'd3;
        tick();
        #1 chk("t5_iwait", 64'(bus.iwait), 64'd0);
        tick();
        bus.iREN = 1'b0; bus.ramstate = 2'd0;
        #1 chk("t5_err", 64'(bus.ram_err), 64'd1);
        tick();
        tick();
        #1 chk("t5_err_sticky", 64'(bus.ram_err), 64'd1);
        do_reset();
        #1 chk("t5_err_clr", 64'(bus.ram_err), 64'd0);

        // continuous contention: order of completions
        bus.iREN = 1'b1; bus.dREN = 1'b1; bus.ramstate = 2'd2;
        order = "";
        for (int c = 0; c < 30 && order.len() < 6; c++) begin
            #1;
            if (bus.dwait == 1'b0) order = {order, "D"};
            if (bus.iwait == 1'b0) order = {order, "I"};
            tick();
        end
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = 2'd0;
        exp_order = RR ? "DIDIDI" : "DDDDDD";
        total++;
        if (order != exp_order) begin
            bad++;
            $display("FAIL t6_order: got %s expected %s", order, exp_order);
        end
        tick();
        #1 chk("t6_icount", 64'(bus.icount), RR ? 64'd3 : 64'd0);
        chk("t6_dcount", 64'(bus.dcount), RR ? 64'd3 : 64'd6);

        // randomized traffic, including resets in flight
        for (int c = 0; c < 3000; c++) begin
            RST          = ($urandom_range(0, 99) == 0);
            bus.iREN     = ($urandom_range(0, 3) != 0);
            bus.dREN     = ($urandom_range(0, 2) == 0);
            bus.dWEN     = ($urandom_range(0, 3) == 0);
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            bus.ramstate = 2'($urandom_range(0, 3));
            tick();
        end
        RST = 1'b0;
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
